// File: rtl/ring_init_controller.sv
`default_nettype none
// ============================================================================
// Module   : ring_init_controller
// Purpose  : Clocked supervisor for a single-rail NCL pipeline ring. Drives the
//            ring init pulse, watches synchronized stage outputs, counts token
//            circulations, measures the circulation period and re-initialises
//            a stalled ring a bounded number of times before reporting a fault.
// Revision : 1.0 - initial release
// ============================================================================
module ring_init_controller #(
   parameter int STAGES      = 4,
   parameter int INIT_CYCLES = 20,
   parameter int TIMEOUT     = 255,
   parameter int MAX_RETRY   = 3,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              init_n,
   input  logic              start,
   input  logic              stop,
   input  logic [STAGES-1:0] ring_state,
   output logic              ring_init,
   output logic              running,
   output logic              fault,
   output logic [7:0]        retries,
   output logic [CNT_W-1:0]  token_count,
   output logic [CNT_W-1:0]  period
);

   // Watchdog holds 0..TIMEOUT-1, init counter holds 0..INIT_CYCLES-1.
   localparam int WD_W = (TIMEOUT     < 2) ? 1 : $clog2(TIMEOUT);
   localparam int IC_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES);

   localparam logic [WD_W-1:0]  C_WD_LAST   = WD_W'(TIMEOUT - 1);
   localparam logic [IC_W-1:0]  C_IC_LOAD   = IC_W'(INIT_CYCLES - 1);
   localparam logic [7:0]       C_RETRY_MAX = 8'(MAX_RETRY);
   localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_INIT  = 2'd1,
      ST_RUN   = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // Synchronizer chain plus one delayed copy for edge detection
   logic [STAGES-1:0] sync1_q, sync2_q, sync3_q;

   state_t            state_q,   state_d;
   logic [IC_W-1:0]   ic_q,      ic_d;       // remaining INIT cycles
   logic [WD_W-1:0]   wd_q,      wd_d;       // cycles without any ring change
   logic [CNT_W-1:0]  pc_q,      pc_d;       // cycles since last counted edge
   logic              seen_q,    seen_d;     // an edge already counted in this RUN
   logic [7:0]        retries_q, retries_d;
   logic [CNT_W-1:0]  tok_q,     tok_d;
   logic [CNT_W-1:0]  per_q,     per_d;

   logic w_change;
   logic w_rise;

   assign w_change = |(sync2_q ^ sync3_q);
   assign w_rise   = sync2_q[0] & ~sync3_q[0];

   // Two-flop synchronizer per ring bit, third flop gives the delayed copy
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= ring_state;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Controller state and counter registers
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state_q   <= ST_IDLE;
         ic_q      <= '0;
         wd_q      <= '0;
         pc_q      <= '0;
         seen_q    <= 1'b0;
         retries_q <= '0;
         tok_q     <= '0;
         per_q     <= '0;
      end else begin
         state_q   <= state_d;
         ic_q      <= ic_d;
         wd_q      <= wd_d;
         pc_q      <= pc_d;
         seen_q    <= seen_d;
         retries_q <= retries_d;
         tok_q     <= tok_d;
         per_q     <= per_d;
      end
   end

   // Next-state logic: stop overrides everything, counters move only in RUN
   always_comb begin
      state_d   = state_q;
      ic_d      = ic_q;
      wd_d      = wd_q;
      pc_d      = pc_q;
      seen_d    = seen_q;
      retries_d = retries_q;
      tok_d     = tok_q;
      per_d     = per_q;

      if (stop) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_FAULT: begin
               if (start) begin
                  state_d   = ST_INIT;
                  ic_d      = C_IC_LOAD;
                  retries_d = '0;
                  tok_d     = '0;
                  per_d     = '0;
               end
            end
            ST_INIT: begin
               if (ic_q == '0) begin
                  state_d = ST_RUN;
                  wd_d    = '0;
                  pc_d    = '0;
                  seen_d  = 1'b0;
               end else begin
                  ic_d = ic_q - 1'b1;
               end
            end
            ST_RUN: begin
               if (pc_q != C_CNT_MAX) begin
                  pc_d = pc_q + 1'b1;
               end
               if (w_rise) begin
                  if (tok_q != C_CNT_MAX) begin
                     tok_d = tok_q + 1'b1;
                  end
                  // First edge after entering RUN has no valid reference point
                  if (seen_q) begin
                     per_d = (pc_q == C_CNT_MAX) ? C_CNT_MAX : pc_q + 1'b1;
                  end
                  pc_d   = '0;
                  seen_d = 1'b1;
               end
               // Any change (including an edge) pre-empts a stall this cycle
               if (w_change) begin
                  wd_d = '0;
               end else if (wd_q == C_WD_LAST) begin
                  if (retries_q < C_RETRY_MAX) begin
                     retries_d = retries_q + 8'd1;
                     state_d   = ST_INIT;
                     ic_d      = C_IC_LOAD;
                  end else begin
                     state_d = ST_FAULT;
                  end
               end else begin
                  wd_d = wd_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Ring is held in init whenever the controller is not running it
   assign ring_init   = (state_q != ST_RUN);
   assign running     = (state_q == ST_RUN);
   assign fault       = (state_q == ST_FAULT);
   assign retries     = retries_q;
   assign token_count = tok_q;
   assign period      = per_q;

endmodule
`default_nettype wire

// File: tb/tb_ring_init_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_init_controller
// Purpose  : Directed self-checking bench for ring_init_controller. Instance
//            u_dut uses default parameters; u_dut4 uses CNT_W=4 for saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_init_controller;

   logic        clk;
   logic        init_n;
   logic        start, stop;
   logic [3:0]  ring_j;
   logic        ring_init, running, fault;
   logic [7:0]  retries;
   logic [15:0] token_count, period;

   logic        start2, stop2;
   logic [3:0]  ring2;
   logic        ring_init2, running2, fault2;
   logic [7:0]  retries2;
   logic [3:0]  token_count2, period2;

   int checks   = 0;
   int failures = 0;

   bit ring_en  = 0;
   int ph       = 0;
   bit ring2_en = 0;
   int ph2      = 0;

   ring_init_controller u_dut (
      .clk         (clk),
      .init_n      (init_n),
      .start       (start),
      .stop        (stop),
      .ring_state  (ring_j),
      .ring_init   (ring_init),
      .running     (running),
      .fault       (fault),
      .retries     (retries),
      .token_count (token_count),
      .period      (period)
   );

   ring_init_controller #(.CNT_W(4)) u_dut4 (
      .clk         (clk),
      .init_n      (init_n),
      .start       (start2),
      .stop        (stop2),
      .ring_state  (ring2),
      .ring_init   (ring_init2),
      .running     (running2),
      .fault       (fault2),
      .retries     (retries2),
      .token_count (token_count2),
      .period      (period2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock: land 1 ns after the rising edge, then advance the ring models
   task automatic tick();
      @(posedge clk);
      #1;
      if (ring_en) begin
         ph++;
         if (ph == 8) begin
            ph     = 0;
            ring_j = {ring_j[2:0], ~ring_j[3]};
         end
      end
      if (ring2_en) begin
         ph2++;
         if (ph2 == 10) begin
            ph2      = 0;
            ring2[0] = ~ring2[0];
         end
      end
   endtask

   // Count ticks until the selected running output reaches lvl (bounded)
   task automatic wait_run(input int inst, input logic lvl, input int exp, input string tag);
      int n = 0;
      while ((((inst == 1) ? running : running2) !== lvl) && (n < 2000)) begin
         tick();
         n++;
      end
      check(tag, n, exp);
   endtask

   initial begin
      init_n = 1'b0;
      start  = 1'b0;
      stop   = 1'b0;
      ring_j = 4'd0;
      start2 = 1'b0;
      stop2  = 1'b0;
      ring2  = 4'd0;

      // Reset values
      #1;
      check("rst_ring_init", ring_init, 1);
      check("rst_running", running, 0);
      check("rst_fault", fault, 0);
      check("rst_retries", retries, 0);
      check("rst_token", token_count, 0);
      check("rst_period", period, 0);
      #12;
      init_n = 1'b1;
      tick();
      tick();

      // Start: 20-cycle init pulse, then RUN with ring toggling every 8 clk
      start = 1'b1;
      tick();
      start = 1'b0;
      check("init_ring_init", ring_init, 1);
      wait_run(1, 1'b1, 20, "init_len1");
      check("run_ring_init", ring_init, 0);
      ring_en = 1;
      ph      = 0;
      repeat (300) tick();
      check("tok5", token_count, 5);
      check("period64", period, 64);
      check("run_fault", fault, 0);
      check("run_running", running, 1);

      // Freeze just after a ring change; stall after sync latency + TIMEOUT
      while (ph != 0) tick();
      ring_en = 0;
      wait_run(1, 1'b0, 258, "stall1_time");
      check("stall1_retries", retries, 1);
      check("stall1_ring_init", ring_init, 1);
      wait_run(1, 1'b1, 20, "reinit_len1");
      wait_run(1, 1'b0, 255, "stall2_time");
      for (int k = 2; k <= 4; k++) begin
         check("stall_retries", retries, (k < 4) ? k : 3);
         check("stall_fault", fault, (k == 4) ? 1 : 0);
         if (k < 4) begin
            wait_run(1, 1'b1, 20, "reinit_len");
            wait_run(1, 1'b0, 255, "stall_time");
         end
      end
      check("fault_ring_init", ring_init, 1);
      check("fault_tok_kept", token_count, 5);
      check("fault_period_kept", period, 64);

      // Start from FAULT clears counters; start held through INIT is ignored
      start = 1'b1;
      tick();
      check("restart_retries", retries, 0);
      check("restart_tok", token_count, 0);
      check("restart_period", period, 0);
      check("restart_fault", fault, 0);
      wait_run(1, 1'b1, 20, "init_len_start_held");
      start = 1'b0;

      // stop lands in the same cycle as a stall: IDLE wins, no retry
      repeat (254) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_running", running, 0);
      check("stop_ring_init", ring_init, 1);
      check("stop_retries", retries, 0);
      check("stop_fault", fault, 0);
      repeat (30) tick();
      check("stop_stays_idle", running, 0);

      // CNT_W=4 instance: edges every 20 clk saturate count and period
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      wait_run(2, 1'b1, 20, "init_len_w4");
      ring2_en = 1;
      ph2      = 0;
      repeat (60) tick();
      check("w4_tok3", token_count2, 3);
      check("w4_period_sat", period2, 15);
      repeat (340) tick();
      check("w4_tok_sat", token_count2, 15);
      check("w4_period_sat2", period2, 15);

      // Short async reset mid-RUN
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_run(1, 1'b1, 20, "init_len_pre_rst");
      #2;
      init_n = 1'b0;
      #1;
      check("arst_ring_init", ring_init, 1);
      check("arst_running", running, 0);
      check("arst_ring_init2", ring_init2, 1);
      check("arst_running2", running2, 0);
      check("arst_tok2", token_count2, 0);
      check("arst_period2", period2, 0);
      check("arst_fault", fault, 0);
      #1;
      init_n = 1'b1;
      repeat (30) tick();
      check("arst_idle", running2, 0);
      check("arst_idle_tok2", token_count2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ring_init_controller.md
Name: ring_init_controller

Overview:
Clocked supervisor for the single-rail NCL pipeline ring. It sequences the ring's init pulse, then monitors the ring's stage outputs through synchronizers. It counts token circulations, measures the circulation period, and detects a stalled ring with a watchdog. On a stall it re-initialises the ring a bounded number of times before declaring a fault. It sits between the clocked test/control domain and the clockless ring.

Parameters:
STAGES, 4, number of ring stages monitored (width of ring_state)
INIT_CYCLES, 20, clk cycles ring_init is held high per init pulse (>=1)
TIMEOUT, 255, clk cycles without any ring_state change that constitutes a stall (>=2)
MAX_RETRY, 3, re-init attempts after stalls before FAULT (0..255)
CNT_W, 16, width of token_count and period

Ports:
clk  input  1  controller clock
init_n  input  1  reset, asynchronous, active-low
start  input  1  pulse: begin init sequence from IDLE or FAULT
stop  input  1  pulse: abort to IDLE from any state
ring_state  input  STAGES  asynchronous stage outputs of the ring (bit 0 = first stage)
ring_init  output  1  active-high init to every ring stage
running  output  1  high in RUN
fault  output  1  high in FAULT
retries  output  8  stalls seen since last start
token_count  output  CNT_W  rising edges of synced ring_state[0] since last start, saturating
period  output  CNT_W  clk cycles between the last two counted edges, saturating

Behaviour:
- Reset (init_n low, async): state IDLE, ring_init=1, running=0, fault=0, retries=0, token_count=0, period=0, all counters 0, synchronizer flops 0.
- ring_state passes through a 2-flop synchronizer per bit. All edge detection uses the synced value and its 1-cycle delayed copy. Latency from a ring change to a detected edge is 2-3 clk.
- States: IDLE, INIT, RUN, FAULT.
- IDLE: ring_init=1 holds the ring quiescent. start -> INIT. start also clears retries, token_count and period, and loads the init counter.
- INIT: ring_init=1 for exactly INIT_CYCLES cycles, counted from the cycle after entry. Then -> RUN, and ring_init=0 from the first RUN cycle. Watchdog and period counters clear on entry to RUN.
- RUN: ring_init=0, running=1.
  - Any bit of synced ring_state differing from its delayed copy clears the watchdog. Otherwise the watchdog increments.
  - On a rising edge of synced bit 0: token_count increments, saturating at all-ones. period latches the period counter + 1, and the period counter clears. The first edge after entering RUN updates token_count only; period is left unchanged.
  - period counter saturates at all-ones.
  - Watchdog reaching TIMEOUT is a stall:
    - if retries < MAX_RETRY: retries+1, -> INIT (re-init pulse); token_count and period are kept.
    - else: -> FAULT.
- FAULT: fault=1, ring_init=1, all counters frozen. start -> INIT with the same clearing as from IDLE.
- stop has priority over start and over a stall in the same cycle. From any state: -> IDLE next cycle, ring_init=1, outputs retain their values except running/fault, which go low.
- start while in INIT or RUN is ignored.
- Edge and stall in the same cycle: the edge clears the watchdog, so no stall is taken.
- init_n asserted mid-run: immediate return to reset values; ring_init goes high asynchronously.

Test Plan:
1. Reset, then start; a ring model toggles stage bits with 8-cycle spacing, so bit 0 rises every 64 clk -> ring_init high for exactly 20 clk, running=1. After 5 bit-0 rises: token_count=5, period=64, fault=0.
2. RUN, then the ring model freezes -> 255 cycles after the last change, ring_init re-pulses for 20 clk and retries=1. Freeze repeatedly -> after the 4th stall fault=1, retries=3, ring_init=1.
3. Fault state, then start -> retries=0, token_count=0, new 20-cycle init pulse, RUN entered.
4. stop and a stall in the same cycle -> IDLE, ring_init=1, retries unchanged. Also: start asserted during INIT has no effect on pulse length (still 20).
5. CNT_W=4 build, ring edges every 20 clk -> token_count saturates at 15; period saturates at 15.
6. init_n pulsed low mid-RUN for a fraction of a clk -> ring_init=1 within that cycle, all outputs at reset values, state IDLE.
